// File: rtl/slave_mem_pkg.sv
// slave_mem_pkg: shared state encoding and default geometry for the
// slave-side local memory controller.
package slave_mem_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 15;
  localparam int unsigned DEF_DATA_WIDTH    = 8;
  localparam int unsigned DEF_MEM_DEPTH_LOG = 12;
  localparam int unsigned DEF_LATENCY       = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/slave_mem_ctrl_if.sv
// slave_mem_ctrl_if: request/response port between a bus slave (master
// modport) and its local memory controller (slave modport).
// addr_err exists only when SLAVE_MEM_RANGE_CHECK_EN is defined.
interface slave_mem_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = slave_mem_pkg::DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = slave_mem_pkg::DEF_DATA_WIDTH
);
  logic                     wr_en;
  logic                     rd_en;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    data_in;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     module_dv;
  logic                     busy;
`ifdef SLAVE_MEM_RANGE_CHECK_EN
  logic                     addr_err;

  modport master (output wr_en, rd_en, addr, data_in,
                  input  data_out, module_dv, busy, addr_err);
  modport slave  (input  wr_en, rd_en, addr, data_in,
                  output data_out, module_dv, busy, addr_err);
`else
  modport master (output wr_en, rd_en, addr, data_in,
                  input  data_out, module_dv, busy);
  modport slave  (input  wr_en, rd_en, addr, data_in,
                  output data_out, module_dv, busy);
`endif
endinterface

// File: rtl/slave_mem_array.sv
// slave_mem_array: single-port synchronous RAM, write-first, registered
// read port. Contents are not reset so it maps onto block RAM.
module slave_mem_array #(
  parameter int unsigned DEPTH_LOG  = slave_mem_pkg::DEF_MEM_DEPTH_LOG,
  parameter int unsigned DATA_WIDTH = slave_mem_pkg::DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG];

  // Write-first port: a write also returns the new word on rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/slave_mem_ctrl.sv
// slave_mem_ctrl: accepts one write or read request from the bus slave,
// completes it with a one-cycle module_dv after LATENCY cycles.
// Optional feature macro: SLAVE_MEM_RANGE_CHECK_EN (adds addr_err and
// blocks out-of-range accesses; otherwise addresses alias).
module slave_mem_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = slave_mem_pkg::DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = slave_mem_pkg::DEF_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH_LOG = slave_mem_pkg::DEF_MEM_DEPTH_LOG,
  parameter int unsigned LATENCY       = slave_mem_pkg::DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rstn,
  slave_mem_ctrl_if.slave   bus
);
  import slave_mem_pkg::*;

  localparam int unsigned CNT_W = 4;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  op_rd_q, op_rd_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  ram_en, ram_we;
  logic                  oor;
  logic                  unused_addr;

  assign unused_addr = ^bus.addr;

`ifdef SLAVE_MEM_RANGE_CHECK_EN
  localparam logic [ADDRESS_WIDTH-1:0] ALL_ONES = '1;
  // Bits above the RAM index but below the slave ID field.
  localparam logic [ADDRESS_WIDTH-1:0] CHK_MASK =
    (ALL_ONES >> 2) & ~(ALL_ONES >> (ADDRESS_WIDTH - MEM_DEPTH_LOG));
  assign oor          = |(bus.addr & CHK_MASK);
  assign bus.addr_err = (state_q == DONE) && err_q;
`else
  assign oor = 1'b0;
`endif

  slave_mem_array #(
    .DEPTH_LOG  (MEM_DEPTH_LOG),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (bus.addr[MEM_DEPTH_LOG-1:0]),
    .wdata (bus.data_in),
    .rdata (rdata)
  );

  // The RAM output register acts as rd_data; it is stable from acceptance
  // until the next accepted request.
  assign rd_val = err_q ? '0 : rdata;

  // Read data is shown straight from rd_data during DONE and latched on
  // leaving DONE, so LATENCY=1 needs no extra pipeline stage.
  assign bus.data_out  = (state_q == DONE && op_rd_q) ? rd_val : data_q;
  assign bus.module_dv = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);

  // Next-state, counter and RAM strobe logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    err_d   = err_q;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wr_en || bus.rd_en) begin
          ram_en  = 1'b1;
          ram_we  = bus.wr_en && !oor;
          op_rd_d = !bus.wr_en;
          err_d   = oor;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1)   state_d = DONE;
          else if (bus.wr_en) state_d = WR_WAIT;
          else                state_d = RD_WAIT;
        end
      end
      WR_WAIT, RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_rd_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
      err_q   <= err_d;
      if (state_q == DONE && op_rd_q) data_q <= rd_val;
    end
  end
endmodule

// File: tb/tb_slave_mem_ctrl.sv
// tb_slave_mem_ctrl: scoreboard bench for slave_mem_ctrl. dut0 runs with
// LATENCY=2, dut1 with LATENCY=1 for the held-request throughput case.
module tb_slave_mem_ctrl;

  typedef struct {
    logic       is_rd;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   dv_cnt0 = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  slave_mem_ctrl_if #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8)) b0 ();
  slave_mem_ctrl_if #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8)) b1 ();

  slave_mem_ctrl #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8), .MEM_DEPTH_LOG(12), .LATENCY(2))
    dut0 (.clk(clk), .rstn(rstn), .bus(b0));
  slave_mem_ctrl #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8), .MEM_DEPTH_LOG(12), .LATENCY(1))
    dut1 (.clk(clk), .rstn(rstn), .bus(b1));

  // Scoreboard for dut0: every completion pops one expectation.
  always @(negedge clk) begin
    if (rstn && b0.module_dv === 1'b1) begin
      exp_t e;
      dv_cnt0++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dv got module_dv=1 exp 0 (empty scoreboard)");
      end else begin
        e = sb.pop_front();
        if (e.is_rd && b0.data_out !== e.data) begin
          errors++;
          $display("FAIL rd_data got %h exp %h", b0.data_out, e.data);
        end
`ifdef SLAVE_MEM_RANGE_CHECK_EN
        checks++;
        if (b0.addr_err !== e.err) begin
          errors++;
          $display("FAIL addr_err got %b exp %b", b0.addr_err, e.err);
        end
`endif
      end
    end
  end

  // One request on dut0 with completion-latency and busy checks.
  task automatic req0(input logic wr, input logic rd, input logic [14:0] a,
                      input logic [7:0] d, input logic [7:0] exp_data,
                      input logic exp_err);
    exp_t e;
    int n;
    @(negedge clk);
    b0.wr_en = wr; b0.rd_en = rd; b0.addr = a; b0.data_in = d;
    @(posedge clk);
    e.is_rd = rd && !wr; e.data = exp_data; e.err = exp_err;
    sb.push_back(e);
    #1;
    b0.wr_en = 1'b0; b0.rd_en = 1'b0;
    checks++;
    if (b0.busy !== 1'b1) begin
      errors++; $display("FAIL busy_accept got %b exp 1", b0.busy);
    end
    n = 0;
    while (b0.module_dv !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL dv_latency got %0d exp 1 edges after accept", n);
    end
    checks++;
    if (b0.busy !== 1'b1) begin
      errors++; $display("FAIL busy_at_dv got %b exp 1", b0.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (b0.module_dv !== 1'b0 || b0.busy !== 1'b0) begin
      errors++;
      $display("FAIL dv_one_cycle got dv=%b busy=%b exp 0 0", b0.module_dv, b0.busy);
    end
  endtask

  task automatic test_reset();
    b0.wr_en = 0; b0.rd_en = 0; b0.addr = '0; b0.data_in = '0;
    b1.wr_en = 0; b1.rd_en = 0; b1.addr = '0; b1.data_in = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b0.busy !== 1'b0 || b0.module_dv !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl0 got busy=%b dv=%b exp 0 0", b0.busy, b0.module_dv);
    end
    checks++;
    if (b0.data_out !== 8'h00) begin
      errors++; $display("FAIL reset_data0 got %h exp 00", b0.data_out);
    end
    checks++;
    if (b1.busy !== 1'b0 || b1.module_dv !== 1'b0 || b1.data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut1 got busy=%b dv=%b data=%h exp 0 0 00", b1.busy, b1.module_dv, b1.data_out);
    end
`ifdef SLAVE_MEM_RANGE_CHECK_EN
    checks++;
    if (b0.addr_err !== 1'b0) begin
      errors++; $display("FAIL reset_addr_err got %b exp 0", b0.addr_err);
    end
`endif
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_write();
    req0(1'b1, 1'b0, 15'h0012, 8'hA5, 8'h00, 1'b0);
    checks++;
    if (b0.data_out !== 8'h00) begin
      errors++; $display("FAIL write_keeps_data got %h exp 00", b0.data_out);
    end
  endtask

  task automatic test_read_hold();
    int d0;
    req0(1'b0, 1'b1, 15'h0012, 8'h00, 8'hA5, 1'b0);
    d0 = dv_cnt0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (b0.data_out !== 8'hA5) begin
      errors++; $display("FAIL read_hold got %h exp a5", b0.data_out);
    end
    checks++;
    if (dv_cnt0 != d0) begin
      errors++; $display("FAIL idle_no_dv got %0d exp 0 pulses", dv_cnt0 - d0);
    end
  endtask

  task automatic test_wr_rd_conflict();
    int d0;
    d0 = dv_cnt0;
    req0(1'b1, 1'b1, 15'h0003, 8'h3C, 8'h00, 1'b0);
    checks++;
    if (b0.data_out !== 8'hA5) begin
      errors++; $display("FAIL conflict_no_read got %h exp a5", b0.data_out);
    end
    req0(1'b0, 1'b1, 15'h0003, 8'h00, 8'h3C, 1'b0);
    checks++;
    if (dv_cnt0 - d0 != 2) begin
      errors++; $display("FAIL conflict_dv_count got %0d exp 2", dv_cnt0 - d0);
    end
  endtask

  task automatic test_addr_range();
    req0(1'b1, 1'b0, 15'h0000, 8'h11, 8'h00, 1'b0);
`ifdef SLAVE_MEM_RANGE_CHECK_EN
    req0(1'b1, 1'b0, 15'h1000, 8'h77, 8'h00, 1'b1);
    req0(1'b0, 1'b1, 15'h0000, 8'h00, 8'h11, 1'b0);
    req0(1'b0, 1'b1, 15'h1000, 8'h00, 8'h00, 1'b1);
`else
    req0(1'b1, 1'b0, 15'h1000, 8'h77, 8'h00, 1'b0);
    req0(1'b0, 1'b1, 15'h0000, 8'h00, 8'h77, 1'b0);
`endif
    // Slave ID bits are never part of the RAM index.
    req0(1'b0, 1'b1, 15'h6012, 8'h00, 8'hA5, 1'b0);
  endtask

  task automatic test_reset_abort();
    int d0;
    d0 = dv_cnt0;
    @(negedge clk);
    b0.rd_en = 1'b1; b0.addr = 15'h0003;
    @(posedge clk); #1;
    b0.rd_en = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b0.data_out !== 8'h00 || b0.busy !== 1'b0) begin
      errors++; $display("FAIL abort_state got data=%h busy=%b exp 00 0", b0.data_out, b0.busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    checks++;
    if (dv_cnt0 != d0) begin
      errors++; $display("FAIL abort_no_dv got %0d exp 0 pulses", dv_cnt0 - d0);
    end
    req0(1'b0, 1'b1, 15'h0012, 8'h00, 8'hA5, 1'b0);
  endtask

  // LATENCY=1: held rd_en gives a completion every 2 cycles; wr_en pulses
  // landing in the busy cycle must not reach the RAM.
  task automatic test_back_to_back();
    logic exp_dv;
    @(negedge clk);
    b1.wr_en = 1'b1; b1.addr = 15'h0005; b1.data_in = 8'h5A;
    @(posedge clk); #1;
    b1.wr_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    b1.rd_en = 1'b1; b1.data_in = 8'hFF;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      exp_dv = (i % 2 == 0);
      checks++;
      if (b1.module_dv !== exp_dv) begin
        errors++; $display("FAIL b2b_dv[%0d] got %b exp %b", i, b1.module_dv, exp_dv);
      end
      if (exp_dv) begin
        checks++;
        if (b1.data_out !== 8'h5A) begin
          errors++; $display("FAIL b2b_data[%0d] got %h exp 5a", i, b1.data_out);
        end
      end
      b1.wr_en = (i == 0 || i == 4 || i == 8);
      if (i == 11) b1.rd_en = 1'b0;
      @(posedge clk); #1;
    end
    b1.wr_en = 1'b0;
    checks++;
    if (b1.busy !== 1'b0 || b1.data_out !== 8'h5A) begin
      errors++; $display("FAIL b2b_end got busy=%b data=%h exp 0 5a", b1.busy, b1.data_out);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_wr_rd_conflict();
    test_addr_range();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d exp 0 outstanding", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slave_mem_ctrl.md
# slave_mem_ctrl

Local memory controller sitting directly downstream of each bus slave. It holds a byte-wide single-port RAM and accepts write and read requests from the slave's internal port: write enable, address buffer and parallel data out. It answers every request with a one-cycle `module_dv` pulse after a fixed latency, which releases the slave from its busy-write or busy-read state. On reads it presents the fetched byte, which the slave captures into its transmit buffer.

## Interface
- `ADDRESS_WIDTH`, 15: width of the slave address buffer; the top 2 bits are the slave ID.
- `DATA_WIDTH`, 8: data word width.
- `MEM_DEPTH_LOG`, 12: log2 of RAM depth. Legal range is 1 to ADDRESS_WIDTH-2.
- `LATENCY`, 2: cycles from request acceptance to `module_dv`. Legal range is 1 to 15.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write request, sampled as a level.
- `rd_en` in 1: read request, sampled as a level.
- `addr` in ADDRESS_WIDTH: request address.
- `data_in` in DATA_WIDTH: write data.
- `data_out` out DATA_WIDTH: read data.
- `module_dv` out 1: completion strobe, one cycle wide.
- `busy` out 1: high while a request is in flight.
- `addr_err` out 1: out-of-range flag. Present only with `SLAVE_MEM_RANGE_CHECK_EN`.

## Operation
- Clocking is fixed: one clock and an asynchronous, active-low reset (`clk`, `rstn`).
- States are IDLE, WR_WAIT, RD_WAIT and DONE.
- **IDLE**
  - Requests are sampled only in IDLE.
  - `wr_en`=1: RAM[addr[MEM_DEPTH_LOG-1:0]] is written with `data_in` on this edge. Go to WR_WAIT and load the counter with LATENCY-1.
  - Else `rd_en`=1: read RAM into the internal `rd_data` register on this edge. Go to RD_WAIT and load the counter with LATENCY-1.
  - `wr_en` and `rd_en` both high: the write wins and the read is dropped.
- **WR_WAIT / RD_WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to DONE. With LATENCY=1 the block goes straight to DONE.
- **DONE**
  - `module_dv`=1 for exactly this cycle.
  - On a read, `data_out` is loaded from `rd_data` on the edge entering DONE.
  - Next state is IDLE.
- `wr_en`/`rd_en` asserted outside IDLE are ignored; they are not queued.
- A level still high when the block returns to IDLE is accepted again. The slave drops its enable within one cycle, so a held or repeated write to the same address and data is idempotent.
- `busy` = (state != IDLE).
- `data_out` holds its value until the next read completion. Writes never change it.
- Address wrap without the macro: the upper address bits (slave ID and excess bits) are ignored, so the address aliases modulo 2^MEM_DEPTH_LOG.

## Timing
- Request accepted at edge k: `busy` is high from k, `module_dv` is high in the cycle after edge k+LATENCY-1, and the block is back in IDLE after edge k+LATENCY.
- Back-to-back throughput: one request per LATENCY+1 cycles.
- Reset values:
  - state IDLE
  - `module_dv` 0
  - `busy` 0
  - `data_out` 0
  - `addr_err` 0
  - counter 0
- RAM contents are not reset; they are undefined after power-up.
- Reset mid-operation aborts the request with no `module_dv`. A write already committed at acceptance stays in RAM.

## Configuration
- `SLAVE_MEM_RANGE_CHECK_EN` defined:
  - Address bits [ADDRESS_WIDTH-3:MEM_DEPTH_LOG] are checked at acceptance; any bit set means out of range.
  - Out-of-range write: RAM is not written.
  - Out-of-range read: `data_out` is loaded with 0.
  - The request still completes normally with `module_dv`, so the slave never hangs.
  - `addr_err` pulses high together with that `module_dv` and is 0 otherwise.
- Undefined: there is no `addr_err` port, no check, and the address aliases as described in Operation.

## Structure
- Package `slave_mem_pkg`:
  - state encoding localparams (IDLE=2'd0, WR_WAIT=2'd1, RD_WAIT=2'd2, DONE=2'd3)
  - default values of `ADDRESS_WIDTH`, `DATA_WIDTH`, `MEM_DEPTH_LOG` and `LATENCY`
- Sub-module `slave_mem_array`: single-port synchronous RAM with write-first behaviour and registered read, inferable as block RAM. The controller holds only the FSM, the counter and the output registers.

## Test plan
- Reset, then write addr=0x0012 with data 0xA5 (LATENCY=2): `module_dv` is high exactly 2 cycles after acceptance, `busy` is high for 2 cycles, and `data_out` is unchanged at 0.
- Read of 0x0012 after that write: `module_dv` after 2 cycles with `data_out`=0xA5, held through a subsequent idle period of 10 cycles or more.
- `wr_en` and `rd_en` high together at addr 0x0003 with data 0x3C: a write is performed and no read is performed. A following read returns 0x3C and exactly 2 `module_dv` pulses are seen in total.
- Assert `rstn`=0 one cycle after accepting a read: no `module_dv` and `data_out`=0. A later read of a previously written address still returns the written byte.
- Macro on, write to addr 0x1000 (bit 12 set, depth 4096): `addr_err` and `module_dv` pulse together and RAM[0x000] is unchanged. Macro off: the same write aliases to RAM[0x000].
- LATENCY=1 with back-to-back reads driven as held `rd_en`: a `module_dv` every 2 cycles, and `wr_en` pulses during `busy` are ignored.
